// File: rtl/hp_to_fixed_if.sv
// Handshake bundle between an FP16 producer and the hp_to_fixed decoder.
interface hp_to_fixed_if #(
  parameter int unsigned OUT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      hp_in;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] fx_out;
  logic [1:0]       Exceptions;

  modport master (
    output in_valid, hp_in, out_ready,
    input  in_ready, out_valid, fx_out, Exceptions
  );

  modport slave (
    input  in_valid, hp_in, out_ready,
    output in_ready, out_valid, fx_out, Exceptions
  );
endinterface

// File: rtl/hp_to_fixed.sv
// FP16 to signed fixed-point converter: bit-serial shifter, round-to-nearest-even,
// saturation and the FP16 adder's 2-bit exception code.
module hp_to_fixed #(
  parameter int unsigned OUT_W  = 16,
  parameter int unsigned FRAC_W = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  hp_to_fixed_if.slave bus
);
  localparam int unsigned MAG_W = OUT_W + 1;
  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

  state_t           state_q, state_d;
  logic [MAG_W-1:0] mag_q, mag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             left_q, left_d;
  logic             sign_q, sign_d;
  logic             guard_q, guard_d;
  logic             sticky_q, sticky_d;
  logic             ovf_q, ovf_d;
  logic [OUT_W-1:0] fx_q, fx_d;
  logic [1:0]       exc_q, exc_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [4:0]        e_c;
  logic [9:0]        man_c;
  logic signed [7:0] s_c;
  logic signed [7:0] neg_c;
  logic [CNT_W-1:0]  n_c;
  logic [MAG_W-1:0]  rnd_c;
  logic [MAG_W-1:0]  lim_c;
  logic [MAG_W-1:0]  rnd_neg_c;

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.fx_out     = fx_q;
  assign bus.Exceptions = exc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mag_q       <= '0;
      cnt_q       <= '0;
      left_q      <= 1'b0;
      sign_q      <= 1'b0;
      guard_q     <= 1'b0;
      sticky_q    <= 1'b0;
      ovf_q       <= 1'b0;
      fx_q        <= '0;
      exc_q       <= 2'b00;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      cnt_q       <= cnt_d;
      left_q      <= left_d;
      sign_q      <= sign_d;
      guard_q     <= guard_d;
      sticky_q    <= sticky_d;
      ovf_q       <= ovf_d;
      fx_q        <= fx_d;
      exc_q       <= exc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    cnt_d       = cnt_q;
    left_d      = left_q;
    sign_d      = sign_q;
    guard_d     = guard_q;
    sticky_d    = sticky_q;
    ovf_d       = ovf_q;
    fx_d        = fx_q;
    exc_d       = exc_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    // Signed shift count; right shifts are capped since later bits only feed sticky
    e_c   = bus.hp_in[14:10];
    man_c = bus.hp_in[9:0];
    s_c   = $signed({3'b000, e_c}) - 8'sd25 + $signed(8'(FRAC_W));
    neg_c = -s_c;
    if (s_c >= 8'sd0)       n_c = CNT_W'(s_c);
    else if (neg_c > 8'sd12) n_c = CNT_W'(12);
    else                     n_c = CNT_W'(neg_c);

    rnd_c     = mag_q + MAG_W'(guard_q && (sticky_q || mag_q[0]));
    lim_c     = (MAG_W'(1) << (OUT_W - 1)) - MAG_W'(!sign_q);
    rnd_neg_c = MAG_W'(0) - rnd_c;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          in_ready_d = 1'b0;
          if (e_c == 5'd31 || (e_c == 5'd0 && man_c != 10'd0)) begin
            fx_d        = '0;
            exc_d       = 2'b11;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else if (e_c == 5'd0) begin
            fx_d        = '0;
            exc_d       = 2'b00;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            sign_d   = bus.hp_in[15];
            mag_d    = MAG_W'({1'b1, man_c});
            guard_d  = 1'b0;
            sticky_d = 1'b0;
            ovf_d    = 1'b0;
            left_d   = (s_c >= 8'sd0);
            cnt_d    = n_c;
            state_d  = (n_c == '0) ? ROUND : SHIFT;
          end
        end
      end
      SHIFT: begin
        if (left_q) begin
          // A set top bit would leave the representable range on this shift
          if (mag_q[OUT_W-1]) begin
            ovf_d   = 1'b1;
            state_d = ROUND;
          end else begin
            mag_d = mag_q << 1;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = ROUND;
          end
        end else begin
          guard_d  = mag_q[0];
          sticky_d = sticky_q | guard_q;
          mag_d    = mag_q >> 1;
          cnt_d    = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ROUND;
        end
      end
      ROUND: begin
        if (ovf_q || rnd_c > lim_c) begin
          exc_d = 2'b01;
          fx_d  = sign_q ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end else if (rnd_c == '0) begin
          exc_d = 2'b10;
          fx_d  = '0;
        end else begin
          exc_d = 2'b00;
          fx_d  = sign_q ? OUT_W'(rnd_neg_c) : OUT_W'(rnd_c);
        end
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_hp_to_fixed.sv
// Bench for hp_to_fixed: directed and random FP16 operands against an exact-arithmetic model.
module tb_hp_to_fixed;
  localparam int OW = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hp_to_fixed_if #(.OUT_W(16)) bus0 ();
  hp_to_fixed_if #(.OUT_W(16)) bus1 ();

  hp_to_fixed #(.OUT_W(16), .FRAC_W(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  hp_to_fixed #(.OUT_W(16), .FRAC_W(8)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  logic        iv   [2];
  logic [15:0] hpv  [2];
  logic        ordy [2];
  logic        ir   [2];
  logic        ov   [2];
  logic [15:0] fx   [2];
  logic [1:0]  ex   [2];

  assign bus0.in_valid  = iv[0];
  assign bus0.hp_in     = hpv[0];
  assign bus0.out_ready = ordy[0];
  assign bus1.in_valid  = iv[1];
  assign bus1.hp_in     = hpv[1];
  assign bus1.out_ready = ordy[1];
  assign ir[0] = bus0.in_ready;
  assign ov[0] = bus0.out_valid;
  assign fx[0] = bus0.fx_out;
  assign ex[0] = bus0.Exceptions;
  assign ir[1] = bus1.in_ready;
  assign ov[1] = bus1.out_valid;
  assign fx[1] = bus1.fx_out;
  assign ex[1] = bus1.Exceptions;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Exact value of the operand scaled by 2^frac, rounded half-to-even, then saturated
  function automatic void model(input logic [15:0] hp, input int frac,
                                output logic [15:0] efx, output logic [1:0] eexc,
                                output int elat);
    int e, s, k, n;
    longint m, q, r, half, lim;
    e = int'(hp[14:10]);
    m = 64'd1024 + longint'(hp[9:0]);
    efx = 16'h0000; eexc = 2'b00; elat = 1;
    if (e == 31 || (e == 0 && hp[9:0] != 10'd0)) begin
      eexc = 2'b11;
    end else if (e != 0) begin
      s = e - 25 + frac;
      if (s >= 0) begin
        q = m << s;
        n = s;
        elat = ((n < OW - 10) ? n : OW - 10) + 1;
      end else begin
        k = -s;
        q = m >> k;
        r = m - (q << k);
        half = longint'(1) << (k - 1);
        if (r > half || (r == half && q[0])) q = q + 1;
        n = (k > 12) ? 12 : k;
        elat = n + 1;
      end
      lim = hp[15] ? 32768 : 32767;
      if (q > lim) begin
        eexc = 2'b01;
        efx  = hp[15] ? 16'h8000 : 16'h7FFF;
      end else if (q == 0) begin
        eexc = 2'b10;
      end else begin
        efx = hp[15] ? 16'(-q) : 16'(q);
      end
    end
  endfunction

  task automatic run(input int d, input logic [15:0] hp, input int hold);
    logic [15:0] efx;
    logic [1:0]  eexc;
    int          elat, lat;
    bit          seen;
    model(hp, (d == 0) ? 0 : 8, efx, eexc, elat);
    chk($sformatf("in_ready_pre d%0d", d), 32'(ir[d]), 32'd1);
    iv[d] = 1'b1; hpv[d] = hp;
    @(posedge clk); #1;
    iv[d] = 1'b0; hpv[d] = 16'($urandom);
    lat = 0; seen = 1'b0;
    while (!seen && lat < 80) begin
      @(posedge clk); lat++; #1;
      if (ov[d]) seen = 1'b1;
    end
    chk($sformatf("latency d%0d hp=%h", d, hp), 32'(lat), 32'(elat));
    chk($sformatf("fx_out d%0d hp=%h", d, hp), 32'(fx[d]), 32'(efx));
    chk($sformatf("exc d%0d hp=%h", d, hp), 32'(ex[d]), 32'(eexc));
    for (int i = 0; i < hold; i++) begin
      iv[d] = 1'($urandom); hpv[d] = 16'($urandom);
      @(posedge clk); #1;
      chk("hold out_valid", 32'(ov[d]), 32'd1);
      chk("hold fx_out", 32'(fx[d]), 32'(efx));
      chk("hold exc", 32'(ex[d]), 32'(eexc));
      chk("hold in_ready", 32'(ir[d]), 32'd0);
    end
    iv[d] = 1'b0;
    ordy[d] = 1'b1;
    @(posedge clk); #1;
    ordy[d] = 1'b0;
    chk("post out_valid", 32'(ov[d]), 32'd0);
    chk("post in_ready", 32'(ir[d]), 32'd1);
    chk("idle fx hold", 32'(fx[d]), 32'(efx));
  endtask

  logic [15:0] dir_tbl [15];

  initial begin
    dir_tbl = '{16'h4000, 16'hE3D0, 16'hF800, 16'h4100, 16'h4300, 16'h3A00, 16'h3800,
                16'h3400, 16'h7BFF, 16'hFBFF, 16'h7C00, 16'hFD04, 16'h011E, 16'h0000,
                16'h8000};
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; hpv[d] = 16'h0000; ordy[d] = 1'b0;
    end
    #12;
    for (int d = 0; d < 2; d++) begin
      chk("reset in_ready", 32'(ir[d]), 32'd1);
      chk("reset out_valid", 32'(ov[d]), 32'd0);
      chk("reset fx_out", 32'(fx[d]), 32'd0);
      chk("reset exc", 32'(ex[d]), 32'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) run(0, dir_tbl[i], (i == 0) ? 5 : 0);
    run(1, 16'h3E00, 2);
    chk("frac8 1.5 value", 32'(fx[1]), 32'h0180);

    for (int i = 0; i < 150; i++) run(0, 16'($urandom), int'($urandom_range(0, 2)));
    for (int i = 0; i < 100; i++) run(1, 16'($urandom), int'($urandom_range(0, 2)));

    // Abort a conversion while it is shifting
    run(0, 16'h3C00, 0);
    iv[0] = 1'b1; hpv[0] = 16'h4000;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset out_valid", 32'(ov[0]), 32'd0);
    chk("midreset in_ready", 32'(ir[0]), 32'd1);
    chk("midreset fx_out", 32'(fx[0]), 32'd0);
    chk("midreset exc", 32'(ex[0]), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      chk("midreset no result", 32'(ov[0]), 32'd0);
    end
    run(0, 16'h4000, 0);
    run(0, 16'hE3D0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hp_to_fixed.md
Name: hp_to_fixed

Overview:
- Sequential converter from half-precision floating point (1 sign, 5 exponent, 10 mantissa bits) to a signed two's-complement fixed-point value with FRAC_W fraction bits.
- It is the decode direction for the FP16 datapath: it unpacks FP16 results, such as those from the half-precision adder/subtractor, into integer/fixed-point form for downstream integer logic.
- Uses an iterative one-bit-per-cycle shifter and round-to-nearest-even.
- Reports exceptions with the same 2-bit code as the FP16 adder.

Parameters:
- OUT_W, 16, width of the signed fixed-point output. Legal range 12..32.
- FRAC_W, 0, number of fraction bits in the output. Legal range 0..OUT_W-2.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  hp_in is valid.
- in_ready  output  1  block can accept an operand.
- hp_in  input  16  FP16 operand.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- fx_out  output  OUT_W  signed fixed-point result.
- Exceptions  output  2  result status: 00 normal, 01 overflow, 10 underflow, 11 invalid input.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - in_ready=1, out_valid=0, fx_out=0, Exceptions=00.
  - All working registers cleared. Reset mid-operation aborts the conversion; no result is produced.
- States: IDLE, SHIFT, ROUND, DONE.
- in_ready=1 only in IDLE. out_valid=1 only in DONE. Accept occurs at an edge with in_valid&&in_ready.
- On accept, capture sign, exponent E and mag = {1, mantissa} (11 bits), zero-extended into an OUT_W+1-bit register.
- Signed shift count s = E - 25 + FRAC_W.
- Special inputs on accept go directly to DONE (latency 1 edge):
  - E=31 (infinity or NaN), or E=0 with mantissa!=0 (denormal): fx_out=0, Exceptions=11.
  - E=0 with mantissa=0 (either sign of zero): fx_out=0, Exceptions=00.
- Normal inputs, shift count n:
  - s>=0: n=s, left shifts.
  - s<0: n=min(-s,12), right shifts.
  - n=0: go to ROUND directly. Otherwise go to SHIFT with a down-counter loaded with n.
- SHIFT: one bit per cycle.
  - Left shift: if mag[OUT_W-1]=1 before a shift, set the ovf flag and go to ROUND immediately (early abort).
  - Right shift: guard <= mag[0]; sticky <= sticky|guard. mag shifts right with 0 in.
  - Go to ROUND when the counter reaches 0.
- ROUND: one cycle.
  - RNE: increment mag if guard && (sticky || mag[0]). Left-shift paths have guard=sticky=0.
  - Limit L = 2^(OUT_W-1)-1 for positive inputs, 2^(OUT_W-1) for negative inputs.
  - If ovf or mag>L: Exceptions=01; fx_out saturates to 0x7FFF.. (positive) or 0x8000.. (negative).
  - Else if rounded mag==0: Exceptions=10, fx_out=0.
  - Else: Exceptions=00, fx_out = sign ? -mag : mag (truncated to OUT_W).
  - Then go to DONE.
- Latency: out_valid rises n+1 edges after the accept edge for normal inputs, and 1 edge after for special inputs.
- DONE:
  - fx_out and Exceptions are held stable while out_ready=0.
  - On the edge where out_ready=1, clear out_valid and go to IDLE. in_ready rises on the same edge.
  - No overlap: a new operand is accepted no earlier than the edge after the output handshake.
- in_valid while busy is ignored; hp_in is don't-care outside the accept edge.
- fx_out/Exceptions hold their last values in IDLE and are only updated in ROUND or on a special-input accept.

Test Plan (OUT_W=16, FRAC_W=0 unless stated):
- Basic conversions and latency:
  - 0x4000 (2.0) -> fx_out=0x0002, Exc=00, out_valid 10 edges after accept.
  - 0xE3D0 (-1000) -> 0xFC18, Exc=00, latency 2.
  - 0xF800 (-32768) -> 0x8000, Exc=00.
- Rounding:
  - 0x4100 (2.5) -> 2.
  - 0x4300 (3.5) -> 4.
  - 0x3A00 (0.75) -> 1, Exc=00.
  - 0x3800 (0.5) -> 0, Exc=10.
  - 0x3400 (0.25) -> 0, Exc=10 (12-shift cap).
- Overflow and FRAC_W:
  - 0x7BFF (65504) -> 0x7FFF, Exc=01.
  - 0xFBFF -> 0x8000, Exc=01.
  - FRAC_W=8 with 0x3E00 (1.5) -> 0x0180, Exc=00.
- Special inputs:
  - 0x7C00, 0xFD04, 0x011E -> fx_out=0, Exc=11, latency 1.
  - 0x0000 and 0x8000 -> 0, Exc=00.
- Handshake:
  - Hold out_ready=0 for 5 cycles in DONE -> out_valid, fx_out, Exc stable; in_ready=0; in_valid pulses ignored.
  - Back-to-back operands -> each accepted one edge after the prior output handshake.
- Reset mid-operation:
  - Assert rst_n=0 during SHIFT of 0x4000 -> immediate IDLE, out_valid=0, fx_out=0, Exc=00.
  - The next operand converts correctly.
